// File: rtl/sys_feeder.sv
// ---------------------------------------------------------------------------
// sys_feeder
// Feeds a systolic PE row. A pass has three phases:
//   1. ROW weight words are loaded and shifted down the PE chain.
//   2. Feature vectors are streamed from a small prefetch FIFO.
//   3. The skew pipeline drains before the pass completes.
// Lane i of every popped vector is delayed by i extra cycles. This produces
// the diagonal wavefront that the PE vector expects.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pass request, honoured only in IDLE
//   w_valid       weight word valid
//   w_ready       weight word accepted (high only in WLOAD)
//   w_data        weight word
//   f_valid       feature vector valid
//   f_ready       FIFO not full
//   f_data        feature vector, element i targets lane i
//   f_last        final vector of the pass
//   ctrl_out      registered, high while weight_out carries a fresh weight
//   weight_out    registered weight into the head of the PE chain
//   feature_out   registered, skewed feature lanes
//   busy          registered, high whenever the FSM is not IDLE
//   done          one-cycle pulse on the first IDLE cycle after a pass
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; the FIFO may still prefetch vectors
// WLOAD  | accepting ROW weight words, one per w_valid handshake
// STREAM | popping one FIFO entry per cycle while the FIFO is non-empty
// DRAIN  | ROW cycles that flush the skew pipeline after the last vector
// ---------------------------------------------------------------------------
module sys_feeder #(
    parameter int WIDTH = 8,
    parameter int ROW   = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [WIDTH-1:0]           w_data,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [ROW-1:0][WIDTH-1:0]  f_data,
    input  logic                       f_last,
    output logic                       ctrl_out,
    output logic [WIDTH-1:0]           weight_out,
    output logic [ROW-1:0][WIDTH-1:0]  feature_out,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ROW);
    localparam int EW = ROW * WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t state;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] dcnt;

    // ---------------- feature FIFO ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          head_last;
    logic [ROW-1:0][WIDTH-1:0] head_data;

    // Full when the pointers differ only in the wrap bit.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // f_ready ignores a same-cycle pop, so a full FIFO never accepts a push.
    assign f_ready = !full;
    assign push    = f_valid && !full;
    assign pop     = (state == ST_STREAM) && !empty;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_last = head[EW-1];
    assign head_data = head[EW-2:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {f_last, f_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- skew pipeline ----------------
    // Lane i is a chain of i+1 registers. A cycle without a pop feeds zeros,
    // so gaps in the stream show up as zero bubbles on every lane.
    for (genvar i = 0; i < ROW; i++) begin : g_lane
        logic [WIDTH-1:0] stage [i+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    stage[k] <= '0;
                end
            end else begin
                stage[0] <= pop ? head_data[i] : '0;
                for (int k = 1; k <= i; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end

        assign feature_out[i] = stage[i];
    end

    // ---------------- control FSM ----------------
    assign w_ready = (state == ST_WLOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            dcnt       <= '0;
            ctrl_out   <= 1'b0;
            weight_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ctrl_out <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WLOAD;
                        wcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WLOAD: begin
                    if (w_valid) begin
                        weight_out <= w_data;
                        ctrl_out   <= 1'b1;
                        if (wcnt == LAST_IDX) begin
                            state <= ST_STREAM;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (pop && head_last) begin
                        state <= ST_DRAIN;
                        dcnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    // ROW cycles: the last vector leaves lane ROW-1 on the
                    // final drain edge, and done follows one cycle later.
                    if (dcnt == LAST_IDX) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_feeder.sv
// ---------------------------------------------------------------------------
// tb_sys_feeder
// Directed bench for sys_feeder with ROW=3, WIDTH=8, DEPTH=4.
// A table of per-cycle input and expected-output records covers:
//   - weight loading,
//   - FIFO fill in IDLE,
//   - skew,
//   - bubbles.
// Hand-written sequences cover asynchronous reset, both at power-up and in
// the middle of a pass.
// ---------------------------------------------------------------------------
module tb_sys_feeder;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             w_valid;
    logic             w_ready;
    logic [7:0]       w_data;
    logic             f_valid;
    logic             f_ready;
    logic [2:0][7:0]  f_data;
    logic             f_last;
    logic             ctrl_out;
    logic [7:0]       weight_out;
    logic [2:0][7:0]  feature_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_err    = 0;

    sys_feeder #(.WIDTH(8), .ROW(3), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_data      (f_data),
        .f_last      (f_last),
        .ctrl_out    (ctrl_out),
        .weight_out  (weight_out),
        .feature_out (feature_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       w_valid;
        logic [7:0] w_data;
        logic       f_valid;
        logic [7:0] f0, f1, f2;
        logic       f_last;
        logic       e_w_ready;
        logic       e_f_ready;
        logic       e_ctrl;
        logic [7:0] e_weight;
        logic [7:0] e0, e1, e2;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    function automatic vec_t mk(input int st, input int wv, input int wd, input int fv,
                                input int f0, input int f1, input int f2, input int fl,
                                input int er, input int efr, input int ec, input int ew,
                                input int e0, input int e1, input int e2,
                                input int eb, input int ed);
        vec_t v;
        v.start     = 1'(st);
        v.w_valid   = 1'(wv);
        v.w_data    = 8'(wd);
        v.f_valid   = 1'(fv);
        v.f0        = 8'(f0);
        v.f1        = 8'(f1);
        v.f2        = 8'(f2);
        v.f_last    = 1'(fl);
        v.e_w_ready = 1'(er);
        v.e_f_ready = 1'(efr);
        v.e_ctrl    = 1'(ec);
        v.e_weight  = 8'(ew);
        v.e0        = 8'(e0);
        v.e1        = 8'(e1);
        v.e2        = 8'(e2);
        v.e_busy    = 1'(eb);
        v.e_done    = 1'(ed);
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic er, input logic efr, input logic ec,
                           input logic [7:0] ew, input logic [23:0] ef,
                           input logic eb, input logic ed);
        chk("w_ready",     idx, 32'(w_ready),     32'(er));
        chk("f_ready",     idx, 32'(f_ready),     32'(efr));
        chk("ctrl_out",    idx, 32'(ctrl_out),    32'(ec));
        chk("weight_out",  idx, 32'(weight_out),  32'(ew));
        chk("feature_out", idx, 32'(feature_out), 32'(ef));
        chk("busy",        idx, 32'(busy),        32'(eb));
        chk("done",        idx, 32'(done),        32'(ed));
    endtask

    task automatic apply(input vec_t v, input int idx);
        start   = v.start;
        w_valid = v.w_valid;
        w_data  = v.w_data;
        f_valid = v.f_valid;
        f_data  = {v.f2, v.f1, v.f0};
        f_last  = v.f_last;
        @(posedge clk);
        #1;
        chk_all(idx, v.e_w_ready, v.e_f_ready, v.e_ctrl, v.e_weight,
                {v.e2, v.e1, v.e0}, v.e_busy, v.e_done);
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        f_valid = 1'b0;
        f_data  = '0;
        f_last  = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        // Pass A: five vectors are offered in IDLE and the FIFO takes four.
        // Weights 5,6,7 are then loaded, and the stream shows the skew.
        //                  st wv wd  fv f0 f1 f2 fl  wr fr ct wt  l0 l1 l2 bz dn
        tbl.push_back(mk(0, 0, 0,  1, 1, 2, 3, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 4, 5, 6, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 7, 8, 9, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1,10,11,12, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1,13,14,15, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1,13,14,15, 1,  1, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5,  1,13,14,15, 1,  1, 0, 1, 5,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6,  1,13,14,15, 1,  1, 0, 1, 6,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 7,  1,13,14,15, 1,  0, 0, 1, 7,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1,13,14,15, 1,  0, 1, 0, 7,  1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1,13,14,15, 1,  0, 1, 0, 7,  4, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7,  7, 5, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7, 10, 8, 6, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7, 13,11, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7,  0,14,12, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7,  0, 0,15, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 7,  0, 0, 0, 0, 0));
        // Pass B: a weight gap (hold), start while busy (ignored), and a
        // two-cycle bubble between {1,1,1} and {2,2,2}+last.
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 7,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 9,  0, 0, 0, 0, 0,  1, 1, 1, 9,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0,85,  0, 0, 0, 0, 0,  1, 1, 0, 9,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8,  0, 0, 0, 0, 0,  1, 1, 1, 8,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 3,  0, 0, 0, 0, 0,  0, 1, 1, 3,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 1, 1, 0,  0, 1, 0, 3,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1, 2, 2, 2, 1,  0, 1, 0, 3,  0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0, 0));

        // Power-up reset: outputs must be at their reset values before any edge.
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk_all(0, 1'b0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i + 1);
        end

        // Mid-STREAM reset with two entries still in the FIFO.
        apply(mk(0, 0, 0, 1, 1, 2, 3, 0,  0, 1, 0, 3,  0, 0, 0, 0, 0), 101);
        apply(mk(0, 0, 0, 1, 4, 5, 6, 0,  0, 1, 0, 3,  0, 0, 0, 0, 0), 102);
        apply(mk(0, 0, 0, 1, 7, 8, 9, 0,  0, 1, 0, 3,  0, 0, 0, 0, 0), 103);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 3,  0, 0, 0, 1, 0), 104);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1,  0, 0, 0, 1, 0), 105);
        apply(mk(0, 1, 2, 0, 0, 0, 0, 0,  1, 1, 1, 2,  0, 0, 0, 1, 0), 106);
        apply(mk(0, 1, 3, 0, 0, 0, 0, 0,  0, 1, 1, 3,  0, 0, 0, 1, 0), 107);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  1, 0, 0, 1, 0), 108);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all(109, 1'b0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all(110, 1'b0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset: no done pulse, and the old FIFO entries must be gone.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0), 111);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0), 112);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 1, 0), 113);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 1,  0, 0, 0, 1, 0), 114);
        apply(mk(0, 1, 2, 0, 0, 0, 0, 0,  1, 1, 1, 2,  0, 0, 0, 1, 0), 115);
        apply(mk(0, 1, 3, 0, 0, 0, 0, 0,  0, 1, 1, 3,  0, 0, 0, 1, 0), 116);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 1, 0), 117);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 1, 0), 118);
        apply(mk(0, 0, 0, 1, 9, 9, 9, 1,  0, 1, 0, 3,  0, 0, 0, 1, 0), 119);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  9, 0, 0, 1, 0), 120);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 9, 0, 1, 0), 121);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 9, 1, 0), 122);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3,  0, 0, 0, 0, 1), 123);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sys_feeder.md
SYS_FEEDER -- requirements
Module: sys_feeder

Interface
REQ-001 Parameter WIDTH, default 8, data width of every weight and feature lane.
REQ-002 Parameter ROW, default 3, number of PE lanes fed; SHALL be >= 2.
REQ-003 Parameter DEPTH, default 4, feature FIFO entries; SHALL be a power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
REQ-007 w_valid  input  1  weight word valid.
REQ-008 w_ready  output  1  weight word accepted; high only in WLOAD.
REQ-009 w_data  input  WIDTH  weight word.
REQ-010 f_valid  input  1  feature vector valid.
REQ-011 f_ready  output  1  equals not-full of the FIFO.
REQ-012 f_data  input  ROW x WIDTH  feature vector; element i targets lane i.
REQ-013 f_last  input  1  marks the final vector of a pass.
REQ-014 ctrl_out  output  1  registered; high for the cycle weight_out carries a newly loaded weight.
REQ-015 weight_out  output  WIDTH  registered weight into the head of the PE chain.
REQ-016 feature_out  output  ROW x WIDTH  registered, skewed feature lanes into the PE vector.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 done  output  1  one-cycle pulse at end of pass.

Function
REQ-019 FIFO SHALL store DEPTH entries of {f_last, f_data}; push on f_valid && f_ready in any state, including IDLE (prefetch).
REQ-020 f_ready SHALL be low when the FIFO is full, even if a pop occurs in the same cycle.
REQ-021 FSM SHALL have states IDLE, WLOAD, STREAM, DRAIN.
REQ-022 IDLE: start -> WLOAD, weight counter cleared; start in any other state ignored.
REQ-023 WLOAD: w_ready = 1; on each w_valid handshake, weight_out <= w_data and ctrl_out <= 1 at the same edge, counter increments.
REQ-024 WLOAD: on a cycle with no handshake, weight_out holds and ctrl_out <= 0.
REQ-025 WLOAD: the ROW-th handshake SHALL move the FSM to STREAM; outside WLOAD ctrl_out <= 0.
REQ-026 STREAM: pop one entry per cycle whenever the FIFO is non-empty; no pop in any other state.
REQ-027 A vector popped at edge E0 SHALL appear on feature_out[i] after edge E(i); lane i latency = 1 + i cycles.
REQ-028 Cycles without a pop (empty FIFO, non-STREAM state) SHALL inject zero into lane 0 of the skew pipeline; bubbles propagate as zeros.
REQ-029 Popping an entry with f_last = 1 SHALL move the FSM to DRAIN and clear the drain counter.
REQ-030 DRAIN SHALL last exactly ROW cycles, then return to IDLE with done = 1 for that first IDLE cycle only.
REQ-031 done SHALL follow the appearance of the last vector's lane ROW-1 by one cycle.
REQ-032 FIFO pointers SHALL use log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty from pointer MSB compare.
REQ-033 No arithmetic on data; lanes pass unmodified.

Reset
REQ-034 On rst_n low, asynchronously: state IDLE, FIFO empty, all counters 0.
REQ-035 On rst_n low: weight_out, every feature_out lane, ctrl_out, busy and done = 0; f_ready = 1; w_ready = 0.
REQ-036 Reset mid-pass SHALL discard FIFO contents and the in-flight skew data; no done pulse is generated.

Verification (ROW=3, WIDTH=8, DEPTH=4)
REQ-037 Reset: assert rst_n low mid-cycle -> all outputs 0 immediately, f_ready = 1, busy = 0.
REQ-038 Weight load: start, then w_data 5,6,7 back-to-back -> weight_out 5,6,7 with ctrl_out high 3 consecutive cycles, then ctrl_out = 0 and STREAM.
REQ-039 Skew: single vector {1,2,3} with f_last popped at E0 -> lane0 = 1 after E0, lane1 = 2 after E1, lane2 = 3 after E2, done = 1 after E3, busy = 0.
REQ-040 FIFO full: 5 vectors offered in IDLE -> 4 accepted, f_ready low after the 4th, 5th held until STREAM pops.
REQ-041 Bubble: vectors {1,1,1}, gap of 2 cycles, {2,2,2}+last -> each lane shows 1, 0, 0, 2 in consecutive cycles at its skew offset.
REQ-042 Reset mid-STREAM with 2 FIFO entries -> FIFO empty, lanes 0, IDLE, no done pulse.
